// File: rtl/crossbar_in_pkg.sv
// Shared memory-subsystem parameters, used by the input and return crossbars.
package crossbar_in_pkg;

    localparam int MEM_MUX_IN    = 4;   // requesters (PE / config ports)
    localparam int MEM_MUX_OUT   = 4;   // SRAM banks, power of two
    localparam int MEM_BANK_BITS = 2;   // log2(MEM_MUX_OUT)
    localparam int MEM_RAM_AW    = 10;  // per-bank word-address width
    localparam int MEM_DATA_W    = 32;
    localparam int MEM_STRB_W    = MEM_DATA_W / 8;
    localparam int MEM_CNT_W     = 16;

    // Index width that stays legal when there is only one requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crossbar_in_rr_arbiter.sv
// Round-robin arbiter for one bank: the search starts at r_ptr, and the pointer
// moves to one past the winner.
module rr_arbiter
    import crossbar_in_pkg::*;
#(
    parameter int N = MEM_MUX_IN
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N-1:0]         i_req,
    output logic [N-1:0]         o_gnt,
    output logic [idx_w(N)-1:0]  o_idx,
    output logic                 o_vld
);

    localparam int PW = idx_w(N);

    logic [PW-1:0] r_ptr;

    always_comb begin : p_search
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(r_ptr) + i;
            if (j >= N) j = j - N;
            if (!o_vld && i_req[PW'(j)]) begin
                o_vld           = 1'b1;
                o_gnt[PW'(j)]   = 1'b1;
                o_idx           = PW'(j);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (o_vld) begin
            r_ptr <= (o_idx == PW'(N - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/crossbar_in.sv
// Requester-to-bank crossbar: per-bank round-robin arbitration, combinational
// grant, bank access registered one cycle later.
module crossbar_in
    import crossbar_in_pkg::*;
#(
    parameter int MUX_IN    = MEM_MUX_IN,
    parameter int MUX_OUT   = MEM_MUX_OUT,
    parameter int BANK_BITS = MEM_BANK_BITS,
    parameter int RAM_AW    = MEM_RAM_AW
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [MUX_IN-1:0]           i_req,
    input  logic [MUX_IN-1:0]           i_wren,
    input  logic [MUX_IN*32-1:0]        i_addr,
    input  logic [MUX_IN*32-1:0]        i_wdata,
    input  logic [MUX_IN*4-1:0]         i_wstrb,
    output logic [MUX_IN-1:0]           o_gnt,
    output logic [MUX_OUT-1:0]          o_ram_en,
    output logic [MUX_OUT-1:0]          o_ram_wren,
    output logic [MUX_OUT*RAM_AW-1:0]   o_ram_addr,
    output logic [MUX_OUT*32-1:0]       o_ram_wdata,
    output logic [MUX_OUT*4-1:0]        o_ram_wstrb,
    output logic [MUX_OUT*MUX_IN-1:0]   o_peID,
    output logic [15:0]                 o_conflict_cnt
);

    localparam int PW = idx_w(MUX_IN);

    logic [MUX_IN-1:0][31:0]          w_addr;
    logic [MUX_IN-1:0][31:0]          w_wdata;
    logic [MUX_IN-1:0][3:0]           w_wstrb;
    logic [MUX_OUT-1:0][MUX_IN-1:0]   w_bank_req;
    logic [MUX_OUT-1:0][MUX_IN-1:0]   w_bank_gnt;
    logic [MUX_OUT-1:0][PW-1:0]       w_idx;
    logic [MUX_OUT-1:0]               w_vld;
    logic [MUX_IN-1:0]                w_gnt;
    logic                             w_conflict;
    logic [15:0]                      r_conflict_cnt;

    assign w_addr  = i_addr;
    assign w_wdata = i_wdata;
    assign w_wstrb = i_wstrb;

    // Requests are masked during reset so that no grant escapes.
    always_comb begin
        w_bank_req = '0;
        for (int p = 0; p < MUX_IN; p++) begin
            w_bank_req[w_addr[p][2 +: BANK_BITS]][p] = i_req[p] & i_rst_n;
        end
    end

    always_comb begin
        w_gnt = '0;
        for (int b = 0; b < MUX_OUT; b++) begin
            w_gnt = w_gnt | w_bank_gnt[b];
        end
    end

    assign o_gnt      = w_gnt;
    assign w_conflict = |(i_req & ~w_gnt);

    for (genvar b = 0; b < MUX_OUT; b++) begin : g_bank
        logic              r_en;
        logic              r_wren;
        logic [RAM_AW-1:0] r_addr;
        logic [31:0]       r_wdata;
        logic [3:0]        r_wstrb;
        logic [MUX_IN-1:0] r_pe;

        rr_arbiter #(.N(MUX_IN)) u_arb (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_req   (w_bank_req[b]),
            .o_gnt   (w_bank_gnt[b]),
            .o_idx   (w_idx[b]),
            .o_vld   (w_vld[b])
        );

        // Address, data and strobes hold while the bank is idle; only the
        // strobe, write flag and owner bitmap fall back to zero.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_en    <= 1'b0;
                r_wren  <= 1'b0;
                r_addr  <= '0;
                r_wdata <= '0;
                r_wstrb <= '0;
                r_pe    <= '0;
            end else if (w_vld[b]) begin
                r_en    <= 1'b1;
                r_wren  <= i_wren[w_idx[b]];
                r_addr  <= w_addr[w_idx[b]][2+BANK_BITS +: RAM_AW];
                r_wdata <= w_wdata[w_idx[b]];
                r_wstrb <= w_wstrb[w_idx[b]];
                r_pe    <= i_wren[w_idx[b]] ? '0 : w_bank_gnt[b];
            end else begin
                r_en    <= 1'b0;
                r_wren  <= 1'b0;
                r_pe    <= '0;
            end
        end

        assign o_ram_en[b]                       = r_en;
        assign o_ram_wren[b]                     = r_wren;
        assign o_ram_addr[b*RAM_AW +: RAM_AW]    = r_addr;
        assign o_ram_wdata[b*32 +: 32]           = r_wdata;
        assign o_ram_wstrb[b*4 +: 4]             = r_wstrb;
        assign o_peID[b*MUX_IN +: MUX_IN]        = r_pe;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: doc/crossbar_in.md
CROSSBAR_IN -- requirements
Module: crossbar_in

Interface
REQ-001 Parameter MUX_IN, default 4, number of requesters (PE/config ports).
REQ-002 Parameter MUX_OUT, default 4, number of SRAM banks, power of two.
REQ-003 Parameter BANK_BITS, default 2, log2(MUX_OUT).
REQ-004 Parameter RAM_AW, default 10, per-bank word-address width.
REQ-005 i_clk  in  1  single clock, all logic on rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_req  in  MUX_IN  per-requester request valid.
REQ-008 i_wren  in  MUX_IN  1=write, 0=read, per requester.
REQ-009 i_addr  in  MUX_IN*32  byte address, requester p at [p*32+:32].
REQ-010 i_wdata  in  MUX_IN*32  write data.
REQ-011 i_wstrb  in  MUX_IN*4  byte enables.
REQ-012 o_gnt  out  MUX_IN  request accepted this cycle (combinational).
REQ-013 o_ram_en / o_ram_wren  out  MUX_OUT each  bank access strobe / write flag.
REQ-014 o_ram_addr  out  MUX_OUT*RAM_AW  bank word address.
REQ-015 o_ram_wdata / o_ram_wstrb  out  MUX_OUT*32 / MUX_OUT*4  bank write data / byte enables.
REQ-016 o_peID  out  MUX_OUT*MUX_IN  bank b owner bitmap at [b*MUX_IN+:MUX_IN], feeds the return crossbar.
REQ-017 o_conflict_cnt  out  16  saturating count of cycles with at least one denied request.

Function
REQ-018 Bank select = i_addr[2+:BANK_BITS]; bank word address = i_addr[2+BANK_BITS+:RAM_AW].
REQ-019 Each bank arbitrates among requesters targeting it, round-robin, starting the search at pointer r_ptr[b].
REQ-020 Grant to requester k on bank b updates r_ptr[b] <= (k+1) mod MUX_IN; no grant leaves r_ptr[b] unchanged.
REQ-021 At most one grant per bank per cycle; requests to different banks are granted in the same cycle.
REQ-022 o_gnt[p] is asserted in the same cycle as the accepted request; an ungranted requester holds req/addr/data stable until granted.
REQ-023 Granted request in cycle t drives o_ram_* of its bank registered in cycle t+1 (latency 1); otherwise o_ram_en[b]=0 in t+1.
REQ-024 o_peID for bank b is registered alongside o_ram_en[b]: one-hot bit k for a granted read, all-zero for a write or an idle cycle.
REQ-025 When o_ram_en[b]=0, o_ram_wren[b]=0; addr/wdata/wstrb hold their last values.
REQ-026 o_conflict_cnt increments by 1 per cycle with any (i_req[p] & ~o_gnt[p]) and saturates at 16'hFFFF.
REQ-027 All MUX_IN requesters on one bank: each is granted exactly once in every MUX_IN consecutive cycles, none starved.
REQ-028 A requester that drops i_req before grant is simply not granted; no state changes for it.

Reset
REQ-029 On i_rst_n low: o_ram_en, o_ram_wren, o_ram_addr, o_ram_wdata, o_ram_wstrb, o_peID, o_conflict_cnt = 0; all r_ptr = 0.
REQ-030 o_gnt = 0 while i_rst_n low.
REQ-031 Reset mid-access cancels any registered access; no bank strobe is asserted in the first cycle after release unless granted in that cycle.

Structure
REQ-032 MUX_IN, MUX_OUT, BANK_BITS and RAM_AW are defined in the shared memory-subsystem package/header, also used by the return crossbar.
REQ-033 One sub-module, rr_arbiter (MUX_IN requests, pointer register, one-hot grant), is instantiated once per bank.

Verification
REQ-034 Reset released, all i_req=0 -> every output 0, o_conflict_cnt=0.
REQ-035 p0..p3 read addrs 0x0,0x4,0x8,0xC same cycle -> all o_gnt=1; next cycle o_ram_en=4'b1111, o_peID bank b = one-hot bit b, o_ram_addr all 0.
REQ-036 p0..p3 read addr 0x10 held -> grants p0,p1,p2,p3 in consecutive cycles, bank0 o_peID 0001,0010,0100,1000, o_conflict_cnt=3 after 4 cycles.
REQ-037 p2 write addr 0x24, wdata 0xDEADBEEF, wstrb 4'b0011 -> next cycle bank1 en=1, wren=1, addr=2, wdata 0xDEADBEEF, wstrb 0011, o_peID bank1=0.
REQ-038 Continuous conflict for 70000 cycles -> o_conflict_cnt stops at 0xFFFF.
REQ-039 Assert i_rst_n low one cycle after grant -> o_ram_en and o_peID 0 immediately, r_ptr back to 0.
